// File: rtl/vga_frame_capture.sv
// Receive-side VGA capture: recovers frame/line alignment from sync/blank,
// emits a coordinate-tagged 9-bit pixel stream and checks frame geometry.
module vga_frame_capture #(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  localparam int XW             = $clog2(H_ACTIVE),
  localparam int YW             = $clog2(V_ACTIVE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vga_hs,
  input  logic          vga_vs,
  input  logic          vga_blank,
  input  logic [7:0]    vga_r,
  input  logic [7:0]    vga_g,
  input  logic [7:0]    vga_b,
  input  logic          err_clear,
  output logic          pix_valid,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic [8:0]    pix_data,
  output logic          frame_done,
  output logic          locked,
  output logic          line_err,
  output logic          frame_err
);

  // Counters run one step past the active size so over-long lines/frames stay distinguishable.
  localparam int PCW = $clog2(H_ACTIVE + 2);
  localparam int LCW = $clog2(V_ACTIVE + 2);

  typedef enum logic [1:0] {SEEK, ARMED, LINE, GAP} state_t;

  state_t         state, state_nx;
  logic           vs_lvl, hs_lvl, vs_lvl_q, vs_start;
  logic [PCW-1:0] px_cnt, px_cnt_nx;
  logic [LCW-1:0] ln_cnt, ln_cnt_nx;
  logic           bad_frame, bad_frame_nx;
  logic           pix_p0, x_ok_p0, vld_p0;
  logic [XW-1:0]  x_p0;
  logic [YW-1:0]  y_p0;
  logic           line_ev, frame_ev, done_ev;

  function automatic logic [PCW-1:0] px_inc(input logic [PCW-1:0] v);
    return (v == PCW'(H_ACTIVE + 1)) ? v : v + 1'b1;
  endfunction

  function automatic logic [LCW-1:0] ln_inc(input logic [LCW-1:0] v);
    return (v == LCW'(V_ACTIVE + 1)) ? v : v + 1'b1;
  endfunction

  function automatic logic [XW-1:0] clamp_x(input logic [PCW-1:0] v);
    return (v >= PCW'(H_ACTIVE)) ? XW'(H_ACTIVE - 1) : v[XW-1:0];
  endfunction

  function automatic logic [YW-1:0] clamp_y(input logic [LCW-1:0] v);
    return (v >= LCW'(V_ACTIVE)) ? YW'(V_ACTIVE - 1) : v[YW-1:0];
  endfunction

  assign vs_lvl   = SYNC_ACTIVE_LOW ? ~vga_vs : vga_vs;
  assign hs_lvl   = SYNC_ACTIVE_LOW ? ~vga_hs : vga_hs;
  assign vs_start = vs_lvl & ~vs_lvl_q;

  always_comb begin
    state_nx     = state;
    px_cnt_nx    = px_cnt;
    ln_cnt_nx    = ln_cnt;
    bad_frame_nx = bad_frame;
    pix_p0       = 1'b0;
    x_ok_p0      = 1'b1;
    x_p0         = clamp_x(px_cnt);
    y_p0         = clamp_y(ln_cnt);
    line_ev      = 1'b0;
    frame_ev     = 1'b0;
    done_ev      = 1'b0;
    if (vs_start) begin
      // A new frame always wins, including over a pixel arriving this cycle.
      if (state == LINE || state == GAP) begin
        frame_ev = (ln_cnt != LCW'(V_ACTIVE)) || (state == LINE);
        done_ev  = !frame_ev && !bad_frame;
      end
      state_nx     = ARMED;
      px_cnt_nx    = '0;
      ln_cnt_nx    = '0;
      bad_frame_nx = 1'b0;
    end else begin
      case (state)
        ARMED, GAP: begin
          if (vga_blank) begin
            pix_p0    = 1'b1;
            x_p0      = '0;
            px_cnt_nx = PCW'(1);
            state_nx  = LINE;
          end
        end
        LINE: begin
          if (vga_blank) begin
            pix_p0    = 1'b1;
            x_ok_p0   = px_cnt < PCW'(H_ACTIVE);
            px_cnt_nx = px_inc(px_cnt);
          end else begin
            line_ev   = px_cnt != PCW'(H_ACTIVE);
            ln_cnt_nx = ln_inc(ln_cnt);
            state_nx  = GAP;
          end
          if (hs_lvl) line_ev = 1'b1;
        end
        default: ;
      endcase
      if (line_ev) bad_frame_nx = 1'b1;
    end
    vld_p0 = pix_p0 && x_ok_p0 && (ln_cnt < LCW'(V_ACTIVE));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SEEK;
      vs_lvl_q  <= 1'b1;
      px_cnt    <= '0;
      ln_cnt    <= '0;
      bad_frame <= 1'b0;
    end else begin
      state     <= state_nx;
      vs_lvl_q  <= vs_lvl;
      px_cnt    <= px_cnt_nx;
      ln_cnt    <= ln_cnt_nx;
      bad_frame <= bad_frame_nx;
    end
  end

  // p0 -> p1: registered pixel stream and status
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_data   <= '0;
      frame_done <= 1'b0;
      locked     <= 1'b0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      pix_valid  <= vld_p0;
      frame_done <= done_ev;
      if (pix_p0) begin
        pix_x    <= x_p0;
        pix_y    <= y_p0;
        pix_data <= {vga_r[7:5], vga_g[7:5], vga_b[7:5]};
      end
      line_err  <= line_ev | (line_err & ~err_clear);
      frame_err <= frame_ev | (frame_err & ~err_clear);
      if (line_ev || frame_ev) locked <= 1'b0;
      else if (done_ev)        locked <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed bench for vga_frame_capture at 32x24 with active-low syncs.
module tb_vga_frame_capture;

  localparam int HA = 32;
  localparam int VA = 24;

  logic       clk = 1'b0;
  logic       reset;
  logic       vga_hs, vga_vs, vga_blank, err_clear;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       pix_valid, frame_done, locked, line_err, frame_err;
  logic [4:0] pix_x, pix_y;
  logic [8:0] pix_data;

  int n_checks = 0;
  int n_errors = 0;

  logic mon_clr = 1'b0;
  int   vcount, data_bad, order_bad, done_cnt, ex, ey;

  vga_frame_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .SYNC_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank(vga_blank), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .err_clear(err_clear), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_data(pix_data), .frame_done(frame_done), .locked(locked),
    .line_err(line_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Raster-order monitor: pixels must arrive as (0,0),(1,0)...(31,23).
  always @(negedge clk) begin
    if (mon_clr) begin
      vcount <= 0; data_bad <= 0; order_bad <= 0; done_cnt <= 0; ex <= 0; ey <= 0;
    end else begin
      if (pix_valid) begin
        vcount <= vcount + 1;
        if (pix_data != 9'h1C1) data_bad <= data_bad + 1;
        if (int'(pix_x) != ex || int'(pix_y) != ey) order_bad <= order_bad + 1;
        ex <= (ex == HA - 1) ? 0 : ex + 1;
        ey <= (ex == HA - 1) ? ey + 1 : ey;
      end
      if (frame_done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    mon_clr = 1'b1;
    @(negedge clk);
    #1;
    mon_clr = 1'b0;
  endtask

  task automatic line(input int npix, input bit clr_at_end);
    for (int i = 0; i < npix; i++) begin
      vga_blank = 1'b1;
      tick();
    end
    vga_blank = 1'b0;
    err_clear = clr_at_end;
    tick();
    err_clear = 1'b0;
    tick();
    vga_hs = 1'b0;
    tick();
    tick();
    vga_hs = 1'b1;
    tick();
    tick();
  endtask

  task automatic vsync();
    vga_vs = 1'b0;
    tick();
    tick();
    vga_vs = 1'b1;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic frame(input int nlines, input int short_idx);
    for (int l = 0; l < nlines; l++) line((l == short_idx) ? HA - 1 : HA, 1'b0);
  endtask

  task automatic clear_errs();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
  endtask

  initial begin
    reset = 1'b0; vga_hs = 1'b1; vga_vs = 1'b1; vga_blank = 1'b0; err_clear = 1'b0;
    vga_r = 8'hE0; vga_g = 8'h00; vga_b = 8'h20;
    mon_clear();
    #3;
    check("rst_valid", pix_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_line_err", line_err, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_done", frame_done, 0);
    check("rst_data", pix_data, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Video before the first vsync is ignored.
    frame(2, -1);
    check("seek_ignored", vcount, 0);

    // Two clean frames.
    vsync();
    mon_clear();
    frame(VA, -1);
    vsync();
    check("f1_count", vcount, HA * VA);
    check("f1_order", order_bad, 0);
    check("f1_data", data_bad, 0);
    check("f1_done", done_cnt, 1);
    check("f1_locked", locked, 1);
    mon_clear();
    frame(VA, -1);
    vsync();
    check("f2_count", vcount, HA * VA);
    check("f2_order", order_bad, 0);
    check("f2_done", done_cnt, 1);
    check("f2_locked", locked, 1);

    // Short line 5.
    mon_clear();
    frame(5, -1);
    line(HA - 1, 1'b0);
    check("short_line_err", line_err, 1);
    check("short_locked", locked, 0);
    frame(VA - 6, -1);
    vsync();
    check("short_count", vcount, HA * VA - 1);
    check("short_done", done_cnt, 0);
    mon_clear();
    frame(VA, -1);
    vsync();
    check("relock_done", done_cnt, 1);
    check("relock_locked", locked, 1);

    // Long frame: 25 lines.
    mon_clear();
    frame(VA + 1, -1);
    check("long_y_hold", pix_y, VA - 1);
    vsync();
    check("long_count", vcount, HA * VA);
    check("long_order", order_bad, 0);
    check("long_frame_err", frame_err, 1);
    check("long_locked", locked, 0);
    check("long_done", done_cnt, 0);
    clear_errs();
    check("clr_frame_err", frame_err, 0);
    check("clr_line_err", line_err, 0);

    // vsync arriving at pixel 10 of line 3.
    frame(3, -1);
    for (int i = 0; i < 10; i++) begin
      vga_blank = 1'b1;
      tick();
    end
    vga_vs = 1'b0;
    tick();
    vga_blank = 1'b0;
    tick();
    vga_vs = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("midline_frame_err", frame_err, 1);
    mon_clear();
    frame(VA, -1);
    vsync();
    check("after_abort_count", vcount, HA * VA);
    check("after_abort_order", order_bad, 0);
    check("after_abort_done", done_cnt, 1);
    check("after_abort_locked", locked, 1);

    // Async reset at pixel (7,7).
    mon_clear();
    frame(7, -1);
    for (int i = 0; i < 7; i++) begin
      vga_blank = 1'b1;
      tick();
    end
    @(posedge clk);
    #2;
    check("pre_rst_valid", pix_valid, 1);
    reset = 1'b0;
    #1;
    check("arst_valid", pix_valid, 0);
    check("arst_locked", locked, 0);
    check("arst_x", pix_x, 0);
    check("arst_y", pix_y, 0);
    check("arst_data", pix_data, 0);
    check("arst_frame_err", frame_err, 0);
    tick();
    vga_blank = 1'b0;
    tick();
    @(negedge clk);
    reset = 1'b1;
    mon_clear();
    frame(3, -1);
    check("post_rst_ignored", vcount, 0);
    vsync();
    mon_clear();
    frame(VA, -1);
    vsync();
    check("post_rst_count", vcount, HA * VA);
    check("post_rst_done", done_cnt, 1);
    check("post_rst_locked", locked, 1);

    // err_clear coinciding with a new short line.
    mon_clear();
    frame(2, -1);
    line(HA - 1, 1'b1);
    check("clr_vs_err_line", line_err, 1);
    check("clr_vs_err_locked", locked, 0);
    clear_errs();
    check("clr_alone_line", line_err, 0);
    check("clr_alone_frame", frame_err, 0);
    frame(VA - 3, -1);
    vsync();
    check("clr_frame_done", done_cnt, 0);
    check("clr_frame_err_after", frame_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
